// File: rtl/td8_core_if.sv
// Bus bundle for td8_core: program memory port, I/O pins, status and debug readback.
interface td8_core_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic            CE;
  logic [DW-1:0]   IN;
  logic [DW-1:0]   OUT;
  logic [AW-1:0]   PADDR;
  logic [DW+3:0]   PDATA;
  logic            HALTED;
  logic            STK_ERR;
  logic [2:0]      regsel;
  logic [DW-1:0]   regdat;

  // Core side: drives the program address, output port and status
  modport master (
    input  CE, IN, PDATA, regsel,
    output OUT, PADDR, HALTED, STK_ERR, regdat
  );

  // Board side: supplies instructions, input pins, enable and debug select
  modport slave (
    output CE, IN, PDATA, regsel,
    input  OUT, PADDR, HALTED, STK_ERR, regdat
  );
endinterface

// File: rtl/td8_core.sv
// td8_core: single-cycle TD4-style CPU with parametrised widths, a hardware
// return stack for CALL/RET, HALT, clock enable and sticky stack-error flag.
// Every enabled edge fetches PDATA at PADDR and retires that instruction.
module td8_core #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int SD = 4
) (
  input logic         CLOCK,
  input logic         RESET,
  td8_core_if.master  bus
);

  localparam int SPW = $clog2(SD + 1);

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_CALL   = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_NOP    = 4'b1010;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_HALT   = 4'b1100;
  localparam logic [3:0] OP_RET    = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  // Unsigned add with the carry kept as the extra top bit
  function automatic logic [DW:0] add_carry(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  logic [AW-1:0]  pc;
  logic [DW-1:0]  reg_a;
  logic [DW-1:0]  reg_b;
  logic [DW-1:0]  reg_out;
  logic           carry;
  logic [SPW-1:0] sp;
  logic           halted;
  logic           stk_err;

  // Sized to the full SP range so SP indexes it without width adaptation;
  // only entries below SD are ever written.
  logic [AW-1:0]  stack [2**SPW];

  logic [3:0]     op;
  logic [DW-1:0]  im;
  logic [DW-1:0]  ch;
  logic [DW:0]    sum;
  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  im_addr;
  logic [SPW-1:0] sp_dec;
  logic           run;
  logic           push_ok;
  logic           pop_ok;

  assign op      = bus.PDATA[DW+3:DW];
  assign im      = bus.PDATA[DW-1:0];
  assign pc_inc  = pc + 1'b1;
  assign im_addr = im[AW-1:0];
  assign sp_dec  = sp - 1'b1;
  assign run     = bus.CE && !halted;
  assign push_ok = (sp < SPW'(SD));
  assign pop_ok  = (sp != '0);
  assign sum     = add_carry(ch, im);

  // ALU operand select from the low opcode bits; OUT B (1001) lands on B naturally
  always_comb begin
    ch = '0;
    case (op[1:0])
      2'b00:   ch = reg_a;
      2'b01:   ch = reg_b;
      2'b10:   ch = bus.IN;
      default: ch = '0;
    endcase
  end

  // Architectural state update: one instruction per enabled, non-halted edge
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pc      <= '0;
      reg_a   <= '0;
      reg_b   <= '0;
      reg_out <= '0;
      carry   <= 1'b0;
      sp      <= '0;
      halted  <= 1'b0;
      stk_err <= 1'b0;
    end else if (run) begin
      pc <= pc_inc;
      case (op)
        // Immediate loads see CH=0, so the carry out is already zero
        OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI: begin
          reg_a <= sum[DW-1:0];
          carry <= sum[DW];
        end
        OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI: begin
          reg_b <= sum[DW-1:0];
          carry <= sum[DW];
        end
        OP_OUT_B, OP_OUT_I: begin
          reg_out <= sum[DW-1:0];
          carry   <= sum[DW];
        end
        OP_CALL: begin
          if (push_ok) begin
            sp <= sp + 1'b1;
            pc <= im_addr;
          end else begin
            stk_err <= 1'b1;
          end
        end
        OP_RET: begin
          if (pop_ok) begin
            sp <= sp_dec;
            pc <= stack[sp_dec];
          end else begin
            stk_err <= 1'b1;
          end
        end
        OP_HALT: begin
          halted <= 1'b1;
          pc     <= pc;
        end
        OP_JNC: begin
          if (!carry) pc <= im_addr;
        end
        OP_JMP: begin
          pc <= im_addr;
        end
        default: begin
          pc <= pc_inc;
        end
      endcase
    end
  end

  // Return-address push; stack contents are not reset
  always_ff @(posedge CLOCK) begin
    if (run && op == OP_CALL && push_ok) begin
      stack[sp] <= pc_inc;
    end
  end

  // Debug readback, each field zero-extended or truncated to DW
  always_comb begin
    bus.regdat = '0;
    case (bus.regsel)
      3'd0:    bus.regdat = DW'(pc);
      3'd1:    bus.regdat = reg_a;
      3'd2:    bus.regdat = reg_b;
      3'd3:    bus.regdat = DW'(carry);
      3'd4:    bus.regdat = reg_out;
      3'd5:    bus.regdat = DW'(sp);
      3'd6:    bus.regdat = DW'({stk_err, halted});
      default: bus.regdat = bus.IN;
    endcase
  end

  assign bus.PADDR   = pc;
  assign bus.OUT     = reg_out;
  assign bus.HALTED  = halted;
  assign bus.STK_ERR = stk_err;

endmodule

// File: tb/tb_td8_core.sv
// Directed bench for td8_core: an 8/8/4 instance for control flow, stack and
// enable behaviour, plus a 16/10 instance for wide data and address wrap.
module tb_td8_core;

  logic CLOCK;
  logic RESET;

  td8_core_if #(.DW(8),  .AW(8))  bus8  ();
  td8_core_if #(.DW(16), .AW(10)) bus16 ();

  logic [11:0] rom8  [256];
  logic [19:0] rom16 [1024];

  assign bus8.PDATA  = rom8[bus8.PADDR];
  assign bus16.PDATA = rom16[bus16.PADDR];

  td8_core #(.DW(8), .AW(8), .SD(4)) dut8 (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus8)
  );

  td8_core #(.DW(16), .AW(10), .SD(4)) dut16 (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic reg8(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    bus8.regsel = sel;
    #1;
    check_val(tag, 32'(bus8.regdat), exp);
  endtask

  task automatic reg16(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    bus16.regsel = sel;
    #1;
    check_val(tag, 32'(bus16.regdat), exp);
  endtask

  task automatic clear8();
    for (int i = 0; i < 256; i++) rom8[i] = 12'hC00;
  endtask

  initial begin
    RESET        = 1'b0;
    bus8.CE      = 1'b0;
    bus8.IN      = '0;
    bus8.regsel  = '0;
    bus16.CE     = 1'b0;
    bus16.IN     = '0;
    bus16.regsel = '0;
    clear8();
    for (int i = 0; i < 1024; i++) rom16[i] = 20'hC0000;

    // Reset with CE low clears everything
    do_reset();
    reg8("rst_pc", 3'd0, 32'h0);
    reg8("rst_a", 3'd1, 32'h0);
    reg8("rst_b", 3'd2, 32'h0);
    reg8("rst_c", 3'd3, 32'h0);
    reg8("rst_out", 3'd4, 32'h0);
    reg8("rst_sp", 3'd5, 32'h0);
    reg8("rst_flags", 3'd6, 32'h0);

    // Counting loop: MOV A,F0; ADD A,01; JNC 1; HALT
    clear8();
    rom8[0] = 12'h3F0; rom8[1] = 12'h001; rom8[2] = 12'hE01; rom8[3] = 12'hC00;
    do_reset();
    bus8.CE = 1'b1;
    tick();
    reg8("loop_a0", 3'd1, 32'hF0);
    tick(2);
    reg8("loop_a1", 3'd1, 32'hF1);
    check_val("loop_pc1", 32'(bus8.PADDR), 32'h1);
    tick(28);
    reg8("loop_aff", 3'd1, 32'hFF);
    reg8("loop_cff", 3'd3, 32'h0);
    tick(2);
    reg8("loop_awrap", 3'd1, 32'h00);
    reg8("loop_cwrap", 3'd3, 32'h1);
    check_val("loop_pc3", 32'(bus8.PADDR), 32'h3);
    tick();
    check_val("loop_halt", 32'(bus8.HALTED), 32'h1);
    check_val("loop_halt_pc", 32'(bus8.PADDR), 32'h3);

    // CALL 10; @10 OUT 55; RET; @1 HALT
    clear8();
    rom8[0] = 12'h810; rom8[16] = 12'hB55; rom8[17] = 12'hD00; rom8[1] = 12'hC00;
    do_reset();
    tick();
    reg8("call_sp1", 3'd5, 32'h1);
    check_val("call_pc", 32'(bus8.PADDR), 32'h10);
    tick();
    check_val("call_out", 32'(bus8.OUT), 32'h55);
    tick();
    reg8("ret_sp0", 3'd5, 32'h0);
    check_val("ret_pc", 32'(bus8.PADDR), 32'h1);
    tick();
    check_val("call_halted", 32'(bus8.HALTED), 32'h1);
    tick(10);
    check_val("halt_hold_pc", 32'(bus8.PADDR), 32'h1);
    reg8("halt_flags", 3'd6, 32'h1);
    check_val("halt_hold_out", 32'(bus8.OUT), 32'h55);
    bus8.CE = 1'b0;
    do_reset();
    check_val("rst_unhalt", 32'(bus8.HALTED), 32'h0);

    // Reset while inside a subroutine with CE low
    bus8.CE = 1'b1;
    tick(2);
    reg8("mid_sp", 3'd5, 32'h1);
    bus8.CE = 1'b0;
    do_reset();
    check_val("mid_rst_pc", 32'(bus8.PADDR), 32'h0);
    check_val("mid_rst_out", 32'(bus8.OUT), 32'h0);
    reg8("mid_rst_sp", 3'd5, 32'h0);

    // Five nested CALLs overflow a 4-deep stack, then one RET
    clear8();
    for (int i = 0; i < 5; i++) rom8[i] = 12'h800 | 12'(i + 1);
    rom8[5] = 12'hD00;
    do_reset();
    bus8.CE = 1'b1;
    tick(4);
    reg8("nest_sp4", 3'd5, 32'h4);
    check_val("nest_pc4", 32'(bus8.PADDR), 32'h4);
    check_val("nest_err0", 32'(bus8.STK_ERR), 32'h0);
    tick();
    check_val("ovf_pc", 32'(bus8.PADDR), 32'h5);
    reg8("ovf_sp", 3'd5, 32'h4);
    check_val("ovf_err", 32'(bus8.STK_ERR), 32'h1);
    tick();
    reg8("nest_ret_sp", 3'd5, 32'h3);
    check_val("nest_ret_pc", 32'(bus8.PADDR), 32'h4);
    check_val("err_sticky", 32'(bus8.STK_ERR), 32'h1);

    // RET on empty stack: NOP; RET; HALT
    clear8();
    rom8[0] = 12'hA00; rom8[1] = 12'hD00; rom8[2] = 12'hC00;
    do_reset();
    tick(2);
    check_val("unf_pc", 32'(bus8.PADDR), 32'h2);
    reg8("unf_sp", 3'd5, 32'h0);
    check_val("unf_err", 32'(bus8.STK_ERR), 32'h1);

    // CE gating: MOV A,00; ADD A,01; JMP 1
    clear8();
    rom8[0] = 12'h300; rom8[1] = 12'h001; rom8[2] = 12'hF01;
    do_reset();
    tick(2);
    reg8("ce_a1", 3'd1, 32'h1);
    bus8.CE = 1'b0;
    tick(2);
    check_val("ce_hold_pc", 32'(bus8.PADDR), 32'h2);
    reg8("ce_hold_a", 3'd1, 32'h1);
    bus8.CE = 1'b1;
    tick();
    check_val("ce_jmp_pc", 32'(bus8.PADDR), 32'h1);
    tick();
    reg8("ce_a2", 3'd1, 32'h2);

    // B / IN / OUT datapath with carries
    clear8();
    rom8[0] = 12'h690; rom8[1] = 12'h100; rom8[2] = 12'h405;
    rom8[3] = 12'h5F0; rom8[4] = 12'h901;
    bus8.IN = 8'h80;
    do_reset();
    tick();
    reg8("inb_b", 3'd2, 32'h10);
    reg8("inb_c", 3'd3, 32'h1);
    tick();
    reg8("movab_a", 3'd1, 32'h10);
    reg8("movab_c", 3'd3, 32'h0);
    tick(2);
    reg8("addb_b", 3'd2, 32'h05);
    reg8("addb_c", 3'd3, 32'h1);
    tick();
    check_val("outb_out", 32'(bus8.OUT), 32'h06);
    reg8("outb_c", 3'd3, 32'h0);
    reg8("reg_in", 3'd7, 32'h80);
    bus8.CE = 1'b0;

    // Wide instance: IN A,1; JMP FFFF (upper bits dropped); @3FF NOP -> wrap
    rom16[0] = 20'h20001; rom16[1] = 20'hFFFFF; rom16[1023] = 20'hA0000;
    bus16.IN = 16'hABCD;
    do_reset();
    bus16.CE = 1'b1;
    tick();
    reg16("w_in_a", 3'd1, 32'hABCE);
    tick();
    check_val("w_jmp_pc", 32'(bus16.PADDR), 32'h3FF);
    reg16("w_reg_pc", 3'd0, 32'h3FF);
    tick();
    check_val("w_wrap_pc", 32'(bus16.PADDR), 32'h000);
    bus16.CE = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
